// File: rtl/instr_fetch_unit_pkg.sv
// Shared opcode encodings and fetch FSM states for the instruction fetch unit.
// The opcode values must stay identical to the ones used by the decoder.
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LW   = 3'b001,
    OP_SW   = 3'b010,
    OP_J    = 3'b011,
    OP_ADD  = 3'b100,
    OP_ADDI = 3'b101,
    OP_SUB  = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_DRAIN,
    S_HALT
  } state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch FSM with redirect and halt handling.
// Optional FETCH_NOP_SKIP_EN: fetched NOPs are dropped instead of presented to decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [IW-1:0]   imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [IW-1:0]   instr_word,
  output logic [2:0]      instr_opcode,
  output logic [PC_W-1:0] instr_pc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
);

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic              imem_req_q;
  logic [PC_W-1:0]   imem_addr_q;
  logic              instr_valid_q;
  logic [IW-1:0]     instr_word_q;
  logic [PC_W-1:0]   instr_pc_q;
  logic              halted_q;
  logic [PC_W-1:0]   pc_inc;

  assign pc_inc       = pc_q + PC_W'(1);
  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_addr_q;
  assign instr_valid  = instr_valid_q;
  assign instr_word   = instr_word_q;
  assign instr_opcode = instr_word_q[IW-1:IW-3];
  assign instr_pc     = instr_pc_q;
  assign halted       = halted_q;

  // NOTE: every register here uses non-blocking assignment so all state
  // updates within one edge see the pre-edge values, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= '0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_valid_q <= 1'b0;
      instr_word_q  <= '0;
      instr_pc_q    <= '0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (redirect) begin
            pc_q <= redirect_pc;
          end else begin
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q;
            state_q     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (imem_valid) begin
            imem_req_q <= 1'b0;
            if (redirect) begin
              pc_q    <= redirect_pc;
              state_q <= S_FETCH;
            end
`ifdef FETCH_NOP_SKIP_EN
            else if (imem_rdata[IW-1:IW-3] == OP_NOP) begin
              pc_q    <= pc_inc;
              state_q <= S_FETCH;
            end
`endif
            else begin
              instr_word_q  <= imem_rdata;
              instr_pc_q    <= pc_q;
              instr_valid_q <= 1'b1;
              state_q       <= S_PRESENT;
            end
          end else if (redirect) begin
            // Request stays up until the stale response arrives and is dropped.
            pc_q    <= redirect_pc;
            state_q <= S_DRAIN;
          end
        end

        S_PRESENT: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            if (instr_opcode == OP_HALT) begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              pc_q    <= redirect ? redirect_pc : pc_inc;
              state_q <= S_FETCH;
            end
          end else if (redirect) begin
            instr_valid_q <= 1'b0;
            pc_q          <= redirect_pc;
            state_q       <= S_FETCH;
          end
        end

        S_DRAIN: begin
          if (imem_valid) begin
            imem_req_q <= 1'b0;
            state_q    <= S_FETCH;
          end
          if (redirect) begin
            pc_q <= redirect_pc;
          end
        end

        S_HALT: begin
          halted_q <= 1'b1;
        end

        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed phases push expected
// (pc, word) pairs; a negedge monitor pops and compares on every handshake.
module tb_instr_fetch_unit;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] word;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_word;
  logic [2:0]  instr_opcode;
  logic [7:0]  instr_pc;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halted;

  instr_fetch_unit #(.PC_W(8), .IW(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_word   (instr_word),
    .instr_opcode (instr_opcode),
    .instr_pc     (instr_pc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halted       (halted)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  exp_t        exp_q[$];
  int          hs_cyc[$];
  logic [15:0] mem[256];
  int          latency  = 0;
  bit          pending  = 0;
  int          cnt      = 0;
  logic [7:0]  m_addr   = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] pc, input logic [15:0] word);
    exp_t e;
    e.pc   = pc;
    e.word = word;
    exp_q.push_back(e);
  endtask

  // Instruction memory: one outstanding request, response after 'latency' cycles.
  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        imem_valid = 1'b0;
        pending    = 0;
      end else if (imem_valid) begin
        imem_valid = 1'b0;
        pending    = 0;
      end else begin
        if (imem_req && !pending) begin
          pending = 1;
          cnt     = latency;
          m_addr  = imem_addr;
        end
        if (pending) begin
          if (cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem[m_addr];
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Monitor: every accepted instruction must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid && instr_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_instr: got pc=%0h word=%0h, required no instruction (t=%0t)",
                   instr_pc, instr_word, $time);
        end else begin
          exp_t e;
          logic [15:0] w;
          e = exp_q.pop_front();
          w = e.word;
          check("instr_pc", 32'(instr_pc), 32'(e.pc));
          check("instr_word", 32'(instr_word), 32'(e.word));
          check("instr_opcode", 32'(instr_opcode), 32'(w[15:13]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset(input bit chk);
    #2;
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    exp_q.delete();
    hs_cyc.delete();
    #1;
    if (chk) begin
      check("rst_imem_req", 32'(imem_req), 0);
      check("rst_imem_addr", 32'(imem_addr), 0);
      check("rst_instr_valid", 32'(instr_valid), 0);
      check("rst_instr_word", 32'(instr_word), 0);
      check("rst_instr_pc", 32'(instr_pc), 0);
      check("rst_halted", 32'(halted), 0);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_instr_valid(input string name);
    for (int i = 0; i < 30; i++) begin
      if (instr_valid) break;
      @(posedge clk);
      #2;
    end
    check(name, 32'(instr_valid), 1);
  endtask

  task automatic end_phase(input string name);
    wait_empty(name);
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000 | 16'(i);
    mem[1] = 16'hA000;
  endtask

  initial begin
    int bad;
    rst_n       = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    fill_mem();

    // Phase 1: zero-latency memory, back-to-back accepts, first request timing.
    apply_reset(1);
    latency = 0;
    push_exp(8'h00, 16'h8000);
    push_exp(8'h01, 16'hA000);
    instr_ready = 1'b1;
    release_reset();
    @(posedge clk);
    #2;
    check("first_req", 32'(imem_req), 1);
    check("first_addr", 32'(imem_addr), 0);
    end_phase("p1_drain");
    check("p1_hs_count", hs_cyc.size(), 2);
    if (hs_cyc.size() >= 2) check("p1_throughput", hs_cyc[1] - hs_cyc[0], 3);

    // Phase 2: decode stalls for 5 cycles; outputs hold, no new request.
    apply_reset(0);
    release_reset();
    wait_instr_valid("p2_valid_seen");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(instr_valid), 1);
      check("stall_word", 32'(instr_word), 32'h8000);
      check("stall_pc", 32'(instr_pc), 0);
      check("stall_req", 32'(imem_req), 0);
    end
    @(posedge clk);
    #2;
    push_exp(8'h00, 16'h8000);
    instr_ready = 1'b1;
    wait_empty("p2_drain");
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) break;
      @(posedge clk);
      #2;
    end
    check("p2_next_addr", 32'(imem_addr), 1);
    repeat (3) @(posedge clk);

    // Phase 3: redirect while waiting on slow memory; stale response dropped.
    apply_reset(0);
    latency = 4;
    push_exp(8'h40, 16'h8040);
    instr_ready = 1'b1;
    release_reset();
    @(posedge clk);
    #2;
    check("p3_in_wait_req", 32'(imem_req), 1);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    @(posedge clk);
    #2;
    redirect = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_valid) break;
      @(posedge clk);
      #2;
    end
    @(posedge clk);
    #2;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) break;
      @(posedge clk);
      #2;
    end
    check("p3_redirect_addr", 32'(imem_addr), 32'h40);
    end_phase("p3_drain");

    // Phase 4: pc wraps 0xFF -> 0x00, then HALT at address 0.
    apply_reset(0);
    latency = 0;
    mem[0]  = 16'hE000;
    push_exp(8'hFF, 16'h80FF);
    push_exp(8'h00, 16'hE000);
    instr_ready = 1'b1;
    release_reset();
    redirect    = 1'b1;
    redirect_pc = 8'hFF;
    @(posedge clk);
    #2;
    redirect = 1'b0;
    wait_empty("p4_drain");
    check("p4_halted", 32'(halted), 1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        redirect    = 1'b1;
        redirect_pc = 8'h10;
      end else begin
        redirect = 1'b0;
      end
      @(negedge clk);
      if (imem_req || instr_valid || !halted) bad++;
    end
    check("p4_quiet_after_halt", bad, 0);
    mem[0]      = 16'h8000;
    instr_ready = 1'b0;

    // Phase 5: NOP at address 3.
    apply_reset(0);
    mem[3] = 16'h0000;
    push_exp(8'h00, 16'h8000);
    push_exp(8'h01, 16'hA000);
    push_exp(8'h02, 16'h8002);
`ifndef FETCH_NOP_SKIP_EN
    push_exp(8'h03, 16'h0000);
`endif
    push_exp(8'h04, 16'h8004);
    instr_ready = 1'b1;
    release_reset();
    end_phase("p5_drain");
    mem[3] = 16'h8003;

    // Phase 6: asynchronous reset in WAIT, then restart from address 0.
    apply_reset(0);
    latency = 4;
    release_reset();
    redirect    = 1'b1;
    redirect_pc = 8'h21;
    @(posedge clk);
    #2;
    redirect = 1'b0;
    @(posedge clk);
    #2;
    check("p6_wait_req", 32'(imem_req), 1);
    check("p6_wait_addr", 32'(imem_addr), 32'h21);
    #1;
    rst_n = 1'b0;
    #1;
    check("p6_async_req", 32'(imem_req), 0);
    check("p6_async_addr", 32'(imem_addr), 0);
    check("p6_async_valid", 32'(instr_valid), 0);
    check("p6_async_halted", 32'(halted), 0);
    repeat (3) @(posedge clk);
    latency = 0;
    push_exp(8'h00, 16'h8000);
    instr_ready = 1'b1;
    release_reset();
    end_phase("p6_drain");

    // Phase 7: redirect coincides with an accepting handshake.
    apply_reset(0);
    push_exp(8'h00, 16'h8000);
    push_exp(8'h10, 16'h8010);
    instr_ready = 1'b1;
    release_reset();
    wait_instr_valid("p7_valid_seen");
    redirect    = 1'b1;
    redirect_pc = 8'h10;
    @(posedge clk);
    #2;
    redirect = 1'b0;
    end_phase("p7_drain");

    // Phase 8: redirect coincides with the memory response in WAIT.
    apply_reset(0);
    push_exp(8'h30, 16'h8030);
    instr_ready = 1'b1;
    release_reset();
    @(posedge clk);
    #2;
    check("p8_resp_present", 32'(imem_valid), 1);
    redirect    = 1'b1;
    redirect_pc = 8'h30;
    @(posedge clk);
    #2;
    redirect = 1'b0;
    end_phase("p8_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state is clocked on the rising edge of clk.
REQ-002 Parameter PC_W, default 8: program-counter width in instruction words.
REQ-003 Parameter IW, default 16: instruction width; opcode is bits [IW-1:IW-3].
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 imem_req  output  1  fetch request to instruction memory, held until imem_valid.
REQ-007 imem_addr  output  PC_W  word address of the fetch; stable while imem_req is high.
REQ-008 imem_valid  input  1  one-cycle response strobe; at most one request outstanding.
REQ-009 imem_rdata  input  IW  instruction word, valid with imem_valid.
REQ-010 instr_valid  output  1  instruction presented to decode.
REQ-011 instr_ready  input  1  decode accepts the presented instruction.
REQ-012 instr_word  output  IW  presented instruction; instr_opcode output 3 bits = instr_word[IW-1:IW-3].
REQ-013 instr_pc  output  PC_W  address of the presented instruction.
REQ-014 redirect  input  1  jump from decode/control, one-cycle pulse.
REQ-015 redirect_pc  input  PC_W  jump target, sampled with redirect.
REQ-016 halted  output  1  high once HALT (opcode 3'b111) has been accepted.

Function
REQ-017 SHALL implement the states FETCH, WAIT, PRESENT, DRAIN and HALT.
REQ-018 FETCH: assert imem_req with imem_addr = pc, then go to WAIT; the request stays high through WAIT.
REQ-019 WAIT: on imem_valid, capture imem_rdata into the output register and go to PRESENT (one cycle from response to instr_valid).
REQ-020 PRESENT: hold instr_valid and stable outputs until instr_valid&&instr_ready.
REQ-021 On acceptance, pc SHALL become pc+1 modulo 2^PC_W (8'hFF wraps to 8'h00) and the state SHALL return to FETCH.
REQ-022 On acceptance of opcode 3'b111, the state SHALL go to HALT instead; in HALT, halted=1, imem_req=0 and instr_valid=0 until reset.
REQ-023 Redirect in FETCH or PRESENT: pc SHALL become redirect_pc, instr_valid SHALL drop next cycle and the state SHALL go to FETCH.
REQ-024 Redirect in WAIT without imem_valid: the state SHALL go to DRAIN and pc SHALL become redirect_pc.
REQ-025 DRAIN: the next imem_valid response SHALL be discarded, then the state SHALL go to FETCH.
REQ-026 Redirect coinciding with imem_valid in WAIT: the response SHALL be discarded and the state SHALL go to FETCH at redirect_pc.
REQ-027 Redirect in the same cycle as an accepting handshake: the instruction counts as accepted, but redirect_pc SHALL override pc+1; a HALT opcode still takes priority and the state goes to HALT.
REQ-028 Redirect in DRAIN SHALL update pc only; redirect in HALT SHALL be ignored.
REQ-029 Throughput SHALL be at most one instruction per 3 cycles (FETCH, WAIT with zero memory wait, PRESENT).

Reset
REQ-030 While rst_n is low: state=FETCH, pc=0, imem_req=0, imem_addr=0, instr_valid=0, instr_word=0, instr_pc=0, halted=0.
REQ-031 Reset asserted mid-fetch SHALL abandon the outstanding request; memory is reset by the same rst_n.
REQ-032 The first imem_req SHALL assert in the first clock edge after rst_n deasserts.

Configuration
REQ-033 Macro FETCH_NOP_SKIP_EN, when defined: a fetched opcode 3'b000 (NOP) SHALL NOT be presented; pc SHALL increment and the state SHALL go straight from WAIT to FETCH.
REQ-034 When FETCH_NOP_SKIP_EN is undefined, NOP SHALL be presented like any other opcode.

Structure
REQ-035 Shared package SHALL hold the opcode constants (NOP 000, LW 001, SW 010, J 011, ADD 100, ADDI 101, SUB 110, HALT 111) and the state enum; these opcode values SHALL match the decoder.
REQ-036 No sub-module SHALL be used; the single FSM and the pc register SHALL live in instr_fetch_unit.

Verification
REQ-037 Reset, zero-latency memory, ready=1, words 0x8000, 0xA000 -> instr_pc 0 then 1, instr_valid every 3rd cycle.
REQ-038 ready=0 for 5 cycles in PRESENT -> instr_word and instr_pc stable, imem_req=0, pc unchanged.
REQ-039 Redirect to 0x40 in WAIT with memory latency 4 -> stale response dropped, next imem_addr=0x40, no stale instr_valid.
REQ-040 pc=0xFF accepted -> next imem_addr=0x00; word 0xE000 accepted -> halted=1, no further imem_req.
REQ-041 With FETCH_NOP_SKIP_EN, word 0x0000 at address 3 -> never presented, next instr_pc=4; without the macro -> presented at instr_pc 3.
REQ-042 rst_n low during WAIT -> all outputs 0 asynchronously, fetch restarts at address 0.
